// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with request handshake, registered read data and a
// hardware clear sweep after reset or on clr. Define RAM_PARITY_EN to add even parity per word.
module ram_sp_clr #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              addr_err,
    output logic              parity_err
);

`ifdef RAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [MEM_W-1:0]  mem [DEPTH];

    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              par_bad;

    logic              ready_nxt;
    logic              rd_valid_nxt;
    logic              addr_err_nxt;
    logic              parity_err_nxt;
    logic [DATA_W-1:0] data_out_nxt;

    assign in_range = (32'(addr) < DEPTH);
    assign rd_word  = mem[addr];

`ifdef RAM_PARITY_EN
    assign wr_word = {^data_in, data_in};
    assign par_bad = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`else
    assign wr_word = data_in;
    assign par_bad = 1'b0;
`endif

    // Next-state, memory port and output decode
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ready_nxt      = 1'b0;
        rd_valid_nxt   = 1'b0;
        addr_err_nxt   = 1'b0;
        parity_err_nxt = 1'b0;
        data_out_nxt   = data_out;
        mem_we         = 1'b0;
        mem_addr       = addr;
        mem_wdata      = wr_word;

        case (state)
            INIT, CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '0;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            IDLE: begin
                ready_nxt = 1'b1;
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b0;
                end else if (req && !in_range) begin
                    addr_err_nxt = 1'b1;
                end else if (req && wr) begin
                    mem_we = 1'b1;
                end else if (req) begin
                    rd_valid_nxt   = 1'b1;
                    data_out_nxt   = rd_word[DATA_W-1:0];
                    parity_err_nxt = par_bad;
                end
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            cnt      <= '0;
            ready    <= 1'b0;
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready    <= ready_nxt;
            data_out <= data_out_nxt;
            rd_valid <= rd_valid_nxt;
            addr_err <= addr_err_nxt;
        end
    end

`ifdef RAM_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Storage has no reset; the sweep zeroes it instead
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: a DEPTH=8 instance driven from a vector table through an
// expected-result queue, plus a DEPTH=6 instance for out-of-range accesses.
module tb_ram_sp_clr;

    logic       clk = 1'b0;
    logic       rst, clr, req, wr;
    logic [2:0] addr;
    logic [3:0] data_in;
    logic       ready, rd_valid, addr_err, parity_err;
    logic [3:0] data_out;

    logic       rst6, clr6, req6, wr6;
    logic [2:0] addr6;
    logic [3:0] din6;
    logic       ready6, rv6, ae6, pe6;
    logic [3:0] dout6;

    always #5 clk = ~clk;

    ram_sp_clr #(.DATA_W(4), .ADDR_W(3), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .req(req), .wr(wr), .addr(addr),
        .data_in(data_in), .ready(ready), .data_out(data_out),
        .rd_valid(rd_valid), .addr_err(addr_err), .parity_err(parity_err)
    );

    ram_sp_clr #(.DATA_W(4), .ADDR_W(3), .DEPTH(6)) dut6 (
        .clk(clk), .rst(rst6), .clr(clr6), .req(req6), .wr(wr6), .addr(addr6),
        .data_in(din6), .ready(ready6), .data_out(dout6),
        .rd_valid(rv6), .addr_err(ae6), .parity_err(pe6)
    );

    typedef struct {
        logic       rst, clr, req, wr;
        logic [2:0] addr;
        logic [3:0] din;
        logic       e_ready, e_rv, e_ae, e_pe;
        logic [3:0] e_dout;
    } vec_t;

    vec_t tv[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vi = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int r, int c, int q, int w, int a, int d,
                                int er, int ev, int ee, int eo);
        vec_t v;
        v.rst = r[0]; v.clr = c[0]; v.req = q[0]; v.wr = w[0];
        v.addr = 3'(a); v.din = 4'(d);
        v.e_ready = er[0]; v.e_rv = ev[0]; v.e_ae = ee[0]; v.e_pe = 1'b0;
        v.e_dout = 4'(eo);
        return v;
    endfunction

    // Drive one vector, queue its expectation, compare once the edge has passed
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; clr = v.clr; req = v.req; wr = v.wr;
        addr = v.addr; data_in = v.din;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d_ready", vi), 32'(ready), 32'(e.e_ready));
        chk($sformatf("v%0d_rd_valid", vi), 32'(rd_valid), 32'(e.e_rv));
        chk($sformatf("v%0d_addr_err", vi), 32'(addr_err), 32'(e.e_ae));
        chk($sformatf("v%0d_parity_err", vi), 32'(parity_err), 32'(e.e_pe));
        chk($sformatf("v%0d_data_out", vi), 32'(data_out), 32'(e.e_dout));
        vi++;
    endtask

    task automatic op6(input int q, input int w, input int a, input int d,
                       input int ev, input int ee, input int eo, input string nm);
        @(negedge clk);
        req6 = q[0]; wr6 = w[0]; addr6 = 3'(a); din6 = 4'(d);
        @(posedge clk);
        #1;
        chk({nm, "_rd_valid"}, 32'(rv6), 32'(ev));
        chk({nm, "_addr_err"}, 32'(ae6), 32'(ee));
        chk({nm, "_data_out"}, 32'(dout6), 32'(eo));
        chk({nm, "_parity_err"}, 32'(pe6), 32'd0);
    endtask

    // Edges from reset release until ready rises on the DEPTH=8 instance (41 = timeout)
    task automatic edges_to_ready(output int n);
        n = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int   n8, n6;
        vec_t v;

        rst = 1'b1; clr = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        rst6 = 1'b1; clr6 = 1'b0; req6 = 1'b0; wr6 = 1'b0; addr6 = '0; din6 = '0;

        for (int i = 0; i < 8; i++) tv.push_back(mk(0, 0, 1, 0, i, 0, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 3, 4'b1010, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 3, 0, 1, 1, 0, 4'b1010));
        for (int i = 0; i < 2; i++) tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1010));
        for (int i = 0; i < 8; i++) tv.push_back(mk(0, 0, 1, 1, i, 4'hF, 1, 0, 0, 4'b1010));
        tv.push_back(mk(0, 1, 1, 0, 2, 0, 0, 0, 0, 4'b1010));
        for (int i = 0; i < 7; i++) tv.push_back(mk(0, 0, 1, 0, 5, 0, 0, 0, 0, 4'b1010));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1010));
        for (int i = 0; i < 8; i++) tv.push_back(mk(0, 0, 1, 0, i, 0, 1, 1, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_ready6", 32'(ready6), 32'd0);
        rst = 1'b0;
        rst6 = 1'b0;

        n8 = 0; n6 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready && n8 == 0) n8 = i;
            if (ready6 && n6 == 0) n6 = i;
            if (n8 != 0 && n6 != 0) break;
        end
        chk("init_edges8", 32'(n8), 32'd8);
        chk("init_edges6", 32'(n6), 32'd6);

        // Out-of-range accesses on the DEPTH=6 instance
        for (int i = 0; i < 6; i++) op6(1, 1, i, i + 1, 0, 0, 0, $sformatf("d6_wr%0d", i));
        op6(1, 0, 1, 0, 1, 0, 2, "d6_rd1");
        op6(1, 1, 7, 4'hF, 0, 1, 2, "d6_wr7");
        op6(1, 0, 6, 0, 0, 1, 2, "d6_rd6");
        op6(0, 0, 0, 0, 0, 0, 2, "d6_idle");
        for (int i = 0; i < 6; i++) op6(1, 0, i, 0, 1, 0, i + 1, $sformatf("d6_chk%0d", i));

        for (int i = 0; i < tv.size(); i++) apply(tv[i]);

        // Reset arriving in the third cycle of a clear sweep
        apply(mk(0, 0, 1, 1, 7, 4'h9, 1, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 7, 0, 1, 1, 0, 4'h9));
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h9));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h9));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h9));
        apply(mk(1, 0, 1, 0, 7, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        edges_to_ready(n8);
        chk("rerst_edges", 32'(n8), 32'd8);
        apply(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
        apply(mk(0, 0, 1, 0, 7, 0, 1, 1, 0, 0));

`ifdef RAM_PARITY_EN
        apply(mk(0, 0, 1, 1, 1, 4'b0111, 1, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 4'b0111));
        dut.mem[1][4] = ~dut.mem[1][4];
        v = mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 4'b0111);
        v.e_pe = 1'b1;
        apply(v);
`else
        v = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        apply(v);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sp_clr.md
# ram_sp_clr

Parametrised single-port synchronous RAM with a request handshake, registered read data and a hardware clear engine. It is the next generation of the team's fixed 8x4 memory: width and depth are configurable, every word is zeroed automatically after reset or on request, and out-of-range accesses are flagged. It sits behind small datapath controllers as local scratch storage.

## Interface

Parameters:
- DATA_W, 4: word width in bits, 1 or more.
- ADDR_W, 3: address width in bits, 1 or more.
- DEPTH, 8: number of words. Must satisfy 2 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  clear request. Sampled only when ready=1.
- req  in  1  access request. Sampled only when ready=1.
- wr  in  1  access type: 1 = write, 0 = read. Qualified by req.
- addr  in  ADDR_W  word address.
- data_in  in  DATA_W  write data.
- ready  out  1  high only in IDLE; accesses and clr are accepted only while it is high.
- data_out  out  DATA_W  registered read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse when data_out carries a new read result.
- addr_err  out  1  one-cycle pulse when an accepted access has addr >= DEPTH.
- parity_err  out  1  one-cycle pulse alongside rd_valid on a parity mismatch; tied 0 when the parity feature is not compiled in.

## Operation

- States: INIT, IDLE, CLEAR. An internal sweep counter cnt is ADDR_W bits wide.
- Reset: state=INIT, cnt=0. All outputs reset to 0: ready, data_out, rd_valid, addr_err, parity_err.
- INIT and CLEAR:
  - Each cycle writes mem[cnt]=0 (with correct parity when enabled) and increments cnt.
  - The cycle that writes DEPTH-1 moves the state to IDLE and sets cnt=0.
  - req and clr are ignored in these states; no rd_valid or addr_err is produced.
- IDLE, priority order:
  - clr=1: enter CLEAR with cnt=0. Any req in the same cycle is dropped.
  - req=1 and addr >= DEPTH: no memory change, data_out unchanged; addr_err pulses next cycle.
  - req=1, wr=1: mem[addr] <= data_in at this edge.
  - req=1, wr=0: data_out <= mem[addr] at this edge; rd_valid pulses for that same cycle.
- Reads see writes that completed on earlier edges; there is no same-cycle read/write on this single port.
- rst asserted mid-sweep or mid-access restarts INIT from address 0. A pending rd_valid or addr_err is cancelled.

## Timing

- Clear duration is exactly DEPTH cycles. With rst released before edge E1, edges E1..E_DEPTH write addresses 0..DEPTH-1, and ready is high after E_DEPTH. For DEPTH=8, ready rises after the 8th edge.
- A clr accepted at edge Ek gives ready=0 from Ek and ready=1 again after edge Ek+DEPTH.
- Read latency is 1 cycle: with req accepted at edge Ek, data_out and rd_valid are valid after Ek, and rd_valid clears at Ek+1 unless another read is accepted.
- Throughput in IDLE is one access per cycle; back-to-back reads keep rd_valid high.
- addr_err has the same 1-cycle latency as rd_valid and never coincides with rd_valid.

## Configuration

- RAM_PARITY_EN defined:
  - Each word is stored as DATA_W+1 bits: data plus an even-parity bit computed from data_in on write.
  - On a read, parity is recomputed; a mismatch sets parity_err with rd_valid for that cycle. data_out is still updated.
  - Clear writes zero data with parity bit 0.
- RAM_PARITY_EN undefined: words are DATA_W bits wide, and parity_err is constant 0.

## Test plan

- Reset, then release: ready=0 for exactly 8 edges (DEPTH=8). Then read all 8 addresses: each returns 4'b0000 with rd_valid=1, and addr_err=0.
- Write 4'b1010 to addr 3 and read addr 3 on the next cycle: data_out=4'b1010 with rd_valid pulsed once. Then idle 2 cycles: data_out holds 4'b1010 and rd_valid=0.
- With DEPTH=6, ADDR_W=3: write to addr 7, then read addr 6. addr_err pulses after each; rd_valid stays 0; data_out is unchanged; mem[0..5] is intact.
- Write 4'b1111 to all addresses, assert clr together with req (read addr 2). The read is dropped, ready=0 for 8 cycles, and all later reads return 0.
- Assert rst at cycle 3 of a CLEAR sweep: ready stays 0 for 8 further edges, then address 0 reads 0.
- With RAM_PARITY_EN defined, write 4'b0111 and read it back: parity_err=0. Force the stored parity bit to flip and read again: parity_err=1 with rd_valid=1 and data_out=4'b0111.
